// File: rtl/nco_freq_meter.sv
// nco_freq_meter: estimates the NCO phase increment by counting net quadrant
// transitions of the sin/cos stream over a gate of 2^GATE_LOG2 valid samples.
module nco_freq_meter #(
    parameter int DW        = 15,
    parameter int PW        = 30,
    parameter int GATE_LOG2 = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 in_valid,
    input  logic [DW-1:0]        sin_i,
    input  logic [DW-1:0]        cos_i,
    output logic                 busy,
    output logic                 meas_valid,
    output logic [PW-1:0]        phi_est,
    output logic [GATE_LOG2+1:0] qcount,
    output logic                 alias_err
);
    localparam int AW = GATE_LOG2 + 2;
    localparam int SH = PW - 2 - GATE_LOG2;
    localparam logic signed [DW-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, PRIME, GATE, REPORT} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 alias_q, alias_d;
    logic [GATE_LOG2-1:0] cnt_q;
    logic [1:0]           qprev_q, q_new, step;
    logic [PW-1:0]        phi_q;
    logic [AW-1:0]        qcount_q;
    logic                 alias_err_q;
    logic                 s_neg, c_neg, smp, arm, last;

    // quadrant index runs counter-clockwise, so a +1 step is a positive quarter turn
    always_comb begin
        s_neg   = $signed(sin_i) < ZERO;
        c_neg   = $signed(cos_i) < ZERO;
        q_new   = {s_neg, s_neg ^ c_neg};
        step    = q_new - qprev_q;
        acc_d   = acc_q + (step == 2'd1 ? AW'(1) : step == 2'd3 ? {AW{1'b1}} : AW'(0));
        alias_d = alias_q | (step == 2'd2);
        smp     = clken & in_valid;
        arm     = clken & (((state_q == IDLE) & start) | (state_q == REPORT));
        last    = (state_q == GATE) & smp & (&cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clken)
            case (state_q)
                IDLE:    state_d = start ? PRIME : IDLE;
                PRIME:   state_d = in_valid ? GATE : PRIME;
                GATE:    state_d = last ? REPORT : GATE;
                default: state_d = continuous ? PRIME : IDLE;
            endcase
    end

    always_comb begin
        busy       = state_q != IDLE;
        meas_valid = state_q == REPORT;
        phi_est    = phi_q;
        qcount     = qcount_q;
        alias_err  = alias_err_q;
    end

    // results latch on the final gate sample so they are already valid while meas_valid is high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q       <= '0;
            alias_q     <= 1'b0;
            cnt_q       <= '0;
            qprev_q     <= '0;
            phi_q       <= '0;
            qcount_q    <= '0;
            alias_err_q <= 1'b0;
        end else begin
            if (arm) begin
                acc_q   <= '0;
                alias_q <= 1'b0;
                cnt_q   <= '0;
            end else if ((state_q == GATE) && smp) begin
                acc_q   <= acc_d;
                alias_q <= alias_d;
                cnt_q   <= cnt_q + 1'b1;
            end
            if (((state_q == PRIME) || (state_q == GATE)) && smp)
                qprev_q <= q_new;
            if (last) begin
                qcount_q    <= acc_d;
                phi_q       <= PW'(acc_d) << SH;
                alias_err_q <= alias_d;
            end
        end
    end
endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: drives a behavioural NCO sample stream into nco_freq_meter
// and checks each report against a scoreboard of expected results.
module tb_nco_freq_meter;
    localparam int DW = 15, PW = 30, G = 10, AW = G + 2;

    logic          clk = 1'b0, reset_n = 1'b0, clken = 1'b1, start = 1'b0;
    logic          continuous = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] sin_i = '0, cos_i = '0;
    logic          busy, meas_valid, alias_err;
    logic [PW-1:0] phi_est;
    logic [AW-1:0] qcount;

    typedef struct {
        logic [AW-1:0] q;
        logic [PW-1:0] phi;
        logic          al;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] phase = '0, inc = '0;
    int            n_chk = 0, n_fail = 0;

    nco_freq_meter #(.DW(DW), .PW(PW), .GATE_LOG2(G)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clken      (clken),
        .start      (start),
        .continuous (continuous),
        .in_valid   (in_valid),
        .sin_i      (sin_i),
        .cos_i      (cos_i),
        .busy       (busy),
        .meas_valid (meas_valid),
        .phi_est    (phi_est),
        .qcount     (qcount),
        .alias_err  (alias_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_meas(input logic [AW-1:0] q, input logic [PW-1:0] phi, input logic al);
        exp_t e;
        e.q   = q;
        e.phi = phi;
        e.al  = al;
        sb.push_back(e);
    endtask

    // one clock of stimulus; the NCO model advances only on accepted samples
    task automatic drive_cycle(input bit v, input bit en, input bit st);
        logic [1:0] qd;
        qd       = phase[PW-1:PW-2];
        in_valid = v;
        clken    = en;
        start    = st;
        sin_i    = DW'($urandom_range(0, 16383));
        cos_i    = DW'($urandom_range(0, 16383));
        if (v) begin
            if (qd[1]) sin_i = ~sin_i;
            if (qd[1] ^ qd[0]) cos_i = ~cos_i;
        end else begin
            if ($urandom_range(0, 1) == 1) sin_i = ~sin_i;
            if ($urandom_range(0, 1) == 1) cos_i = ~cos_i;
        end
        @(posedge clk);
        #1;
        if (v && en) phase = phase + inc;
        in_valid = 1'b0;
        start    = 1'b0;
        clken    = 1'b1;
    endtask

    task automatic run_window(input int n, input int vpct, input int epct, input bit st);
        int got = 0;
        bit v, e, s;
        s = st;
        while (got < n) begin
            v = $urandom_range(1, 100) <= vpct;
            e = $urandom_range(1, 100) <= epct;
            drive_cycle(v, e, s);
            s = 1'b0;
            if (v && e) got++;
        end
    endtask

    task automatic pulse_start();
        drive_cycle(1'b0, 1'b1, 1'b1);
    endtask

    task automatic wait_meas();
        for (int i = 0; i < 20 && sb.size() != 0; i++) drive_cycle(1'b0, 1'b1, 1'b0);
        check("meas_seen", sb.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && clken && meas_valid) begin
            if (sb.size() == 0) begin
                check("spurious_meas", meas_valid, 0);
            end else begin
                e = sb.pop_front();
                check("qcount", qcount, e.q);
                check("phi_est", phi_est, e.phi);
                check("alias_err", alias_err, e.al);
                check("busy_report", busy, 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_phi", phi_est, 0);
        check("rst_qcount", qcount, 0);
        check("rst_alias", alias_err, 0);
        reset_n = 1'b1;
        drive_cycle(1'b1, 1'b1, 1'b0);
        check("idle_ignores_samples", busy, 0);

        phase = '0;
        inc   = 30'h4000000;
        expect_meas(12'h100, 30'h4000000, 1'b0);
        pulse_start();
        check("busy_armed", busy, 1);
        run_window(1025, 100, 100, 1'b0);
        wait_meas();
        check("busy_done", busy, 0);

        inc = 30'h3C000000;
        expect_meas(12'hF00, 30'h3C000000, 1'b0);
        pulse_start();
        run_window(1025, 100, 100, 1'b0);
        wait_meas();

        phase = '0;
        inc   = 30'h20000000;
        expect_meas(12'h000, 30'h0, 1'b1);
        pulse_start();
        run_window(1025, 100, 100, 1'b0);
        wait_meas();

        continuous = 1'b1;
        inc        = 30'h1000000;
        repeat (3) expect_meas(12'h040, 30'h1000000, 1'b0);
        pulse_start();
        for (int w = 0; w < 2; w++) begin
            run_window(1025, 100, 100, 1'b0);
            check("busy_cont_report", busy, 1);
            drive_cycle(1'b0, 1'b1, 1'b0);
            check("busy_cont_rearm", busy, 1);
        end
        continuous = 1'b0;
        run_window(1025, 100, 100, 1'b0);
        wait_meas();
        check("busy_cont_stop", busy, 0);

        inc = 30'h4000000;
        expect_meas(12'h100, 30'h4000000, 1'b0);
        pulse_start();
        run_window(400, 50, 100, 1'b0);
        run_window(625, 50, 100, 1'b1);
        wait_meas();

        inc = 30'h2000000;
        expect_meas(12'h080, 30'h2000000, 1'b0);
        pulse_start();
        run_window(1025, 80, 70, 1'b0);
        for (int i = 0; i < 3; i++) begin
            clken = 1'b0;
            check("meas_hold", meas_valid, 1);
            @(posedge clk);
            #1;
        end
        clken = 1'b1;
        wait_meas();

        inc = 30'h4000000;
        pulse_start();
        run_window(500, 100, 100, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_meas_valid", meas_valid, 0);
        check("midrst_phi", phi_est, 0);
        check("midrst_qcount", qcount, 0);
        check("midrst_alias", alias_err, 0);
        run_window(600, 100, 100, 1'b0);
        check("midrst_idle", busy, 0);

        inc = 30'h3F800000;
        expect_meas(12'hFE0, 30'h3F800000, 1'b0);
        pulse_start();
        run_window(1025, 100, 100, 1'b0);
        wait_meas();

        repeat (5) drive_cycle(1'b0, 1'b1, 1'b0);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
